// File: rtl/nor4_rr_arbiter_pkg.sv
// Shared definitions for the nor4 round-robin arbiter.
//   state_e : FSM state encoding (IDLE=0, OWN=1, GAP=2)
//   NREQ    : number of requesters
//   onehot4 : 2-bit index -> 4-bit one-hot decode
package nor4_rr_arbiter_pkg;

    localparam int unsigned NREQ = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn  = 2'd1,
        StGap  = 2'd2
    } state_e;

    function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/nor4_rr_arbiter_if.sv
// Request/grant bundle between requesting block controllers and the arbiter.
//   req     : request vector, bit n = requester n (level-held until served)
//   gnt     : one-hot grant, zero when nobody owns the resource
//   owner   : index of the current owner, meaningful only while |gnt
//   busy    : registered |gnt
//   nq_idle : high when no request is pending and the resource is free
//   tmo     : one-cycle pulse when an owner was revoked by the hold timeout
// master = requester side, slave = arbiter side.
interface nor4_rr_arbiter_if;
    import nor4_rr_arbiter_pkg::*;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      owner;
    logic            busy;
    logic            nq_idle;
    logic            tmo;

    modport master (
        output req,
        input  gnt,
        input  owner,
        input  busy,
        input  nq_idle,
        input  tmo
    );

    modport slave (
        input  req,
        output gnt,
        output owner,
        output busy,
        output nq_idle,
        output tmo
    );

endinterface

// File: rtl/nor4_arbiter_rr_pick4.sv
// Combinational rotating-priority picker plus nor4 idle detector.
//   i_req  : request vector
//   i_ptr  : index holding highest priority this round
//   o_pick : first set request scanning i_ptr, i_ptr+1, .. i_ptr+3 (mod 4)
//   o_any  : at least one request set
//   o_none : nor4 of the requests (the cell output, reused for idle detection)
module rr_pick4
    import nor4_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_ptr,
    output logic [1:0]      o_pick,
    output logic            o_any,
    output logic            o_none
);

    logic [1:0] w_idx;

    nor4_x0 u_nor4 (
        .i_a  (i_req[0]),
        .i_b  (i_req[1]),
        .i_c  (i_req[2]),
        .i_d  (i_req[3]),
        .o_zn (o_none)
    );

    assign o_any = ~o_none;

    // Scan from the lowest priority upward so the last hit (closest to ptr) wins.
    always_comb begin
        o_pick = i_ptr;
        w_idx  = i_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_idx = i_ptr + 2'(i);
            if (i_req[w_idx]) begin
                o_pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/nor4_x0.sv
// Behavioural model of the mcu9t3v3 nor4_x0 library cell.
//   i_a..i_d : inputs
//   o_zn     : ~(i_a | i_b | i_c | i_d)
module nor4_x0 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_zn
);

    assign o_zn = ~(i_a | i_b | i_c | i_d);

endmodule

// File: rtl/nor4_rr_arbiter.sv
// 4-requester round-robin arbiter for a shared resource.
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   arb      : request/grant bundle (slave side), see nor4_rr_arbiter_if
// Parameters:
//   MAX_HOLD : max consecutive grant cycles per owner, 0 = unlimited
//   CNT_W    : hold counter width, 2**CNT_W must exceed MAX_HOLD
// Grants are registered and one-hot; every release passes through one GAP
// cycle and one IDLE cycle before the next owner is granted.
module nor4_rr_arbiter
    import nor4_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input logic           clk,
    input logic           rst,
    nor4_rr_arbiter_if.slave arb
);

    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic             HoldEn   = (MAX_HOLD != 0);

    state_e          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [1:0]      r_owner;
    logic            r_busy;
    logic            r_tmo;
    logic [1:0]      r_ptr;
    logic [CNT_W-1:0] r_cnt;

    state_e          w_state_nxt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [1:0]      w_owner_nxt;
    logic            w_tmo_nxt;
    logic [1:0]      w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [1:0]      w_pick;
    logic            w_any;
    logic            w_none;
    logic            w_drop;
    logic            w_expire;

    rr_pick4 u_pick (
        .i_req  (arb.req),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_any  (w_any),
        .o_none (w_none)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_tmo_nxt   = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_drop      = 1'b0;
        w_expire    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_gnt_nxt   = onehot4(w_pick);
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StOwn;
                end
            end
            StOwn: begin
                if (r_cnt != CntMax) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                w_drop   = ~arb.req[r_owner];
                w_expire = HoldEn && (r_cnt == HoldLast);
                if (w_drop || w_expire) begin
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = r_owner + 2'd1;
                    // A voluntary drop on the expiry edge is not a revocation.
                    w_tmo_nxt   = ~w_drop;
                    w_state_nxt = StGap;
                end
            end
            StGap: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_gnt   <= '0;
            r_owner <= 2'd0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
            r_ptr   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= |w_gnt_nxt;
            r_tmo   <= w_tmo_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign arb.gnt     = r_gnt;
    assign arb.owner   = r_owner;
    assign arb.busy    = r_busy;
    assign arb.tmo     = r_tmo;
    assign arb.nq_idle = w_none & ~r_busy;

endmodule

// File: tb/tb_nor4_rr_arbiter.sv
// Directed bench for nor4_rr_arbiter: a MAX_HOLD=4 instance (vector table,
// rotation under full load) and a MAX_HOLD=16 instance (long-hold timeout
// period, reset while owning).
module tb_nor4_rr_arbiter;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_vec;
    int n_err;

    nor4_rr_arbiter_if arb_a ();
    nor4_rr_arbiter_if arb_b ();

    nor4_rr_arbiter #(.MAX_HOLD(16), .CNT_W(5)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .arb (arb_a)
    );

    nor4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(5)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .arb (arb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       tmo;
        logic       nq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                       input logic [1:0] o, input logic t, input logic n);
        vec_t v;
        v.rst = r; v.req = q; v.gnt = g; v.owner = o; v.tmo = t; v.nq = n;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic step_a(input logic r, input logic [3:0] q);
        @(negedge clk);
        rst_a = r;
        arb_a.req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic r, input logic [3:0] q);
        @(negedge clk);
        rst_b = r;
        arb_b.req = q;
        @(posedge clk);
        #1;
    endtask

    // Invariants on both instances every cycle.
    always @(negedge clk) begin
        if (!$onehot0(arb_a.gnt) || (|arb_a.gnt && arb_a.nq_idle)) begin
            n_err++;
            $display("FAIL inv_a: gnt=%b nq_idle=%b", arb_a.gnt, arb_a.nq_idle);
        end
        if (!$onehot0(arb_b.gnt) || (|arb_b.gnt && arb_b.nq_idle)) begin
            n_err++;
            $display("FAIL inv_b: gnt=%b nq_idle=%b", arb_b.gnt, arb_b.nq_idle);
        end
    end

    initial begin
        logic [3:0] eg;
        int ph;
        n_vec = 0;
        n_err = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        arb_a.req = 4'h0;
        arb_b.req = 4'h0;

        // rst, req, gnt, owner, tmo, nq_idle  (instance B, MAX_HOLD=4)
        add(1, 4'hF, 4'h0, 0, 0, 0);
        add(1, 4'hF, 4'h0, 0, 0, 0);
        add(1, 4'hF, 4'h0, 0, 0, 0);
        add(0, 4'hF, 4'h1, 0, 0, 0);  // ptr=0 favours i0
        add(1, 4'h6, 4'h0, 0, 0, 0);  // reset while owning
        add(0, 4'h6, 4'h2, 1, 0, 0);
        add(0, 4'h4, 4'h0, 0, 0, 0);  // owner drops -> GAP
        add(0, 4'h4, 4'h0, 0, 0, 0);  // IDLE
        add(0, 4'h4, 4'h4, 2, 0, 0);
        add(0, 4'h0, 4'h0, 0, 0, 1);
        add(0, 4'h0, 4'h0, 0, 0, 1);
        add(0, 4'h9, 4'h8, 3, 0, 0);  // ptr=3 favours i3
        add(0, 4'h9, 4'h8, 3, 0, 0);
        add(0, 4'h9, 4'h8, 3, 0, 0);
        add(0, 4'h9, 4'h8, 3, 0, 0);
        add(0, 4'h9, 4'h0, 0, 1, 0);  // timeout revoke
        add(0, 4'h9, 4'h0, 0, 0, 0);
        add(0, 4'h9, 4'h1, 0, 0, 0);
        add(0, 4'h9, 4'h1, 0, 0, 0);
        add(0, 4'h9, 4'h1, 0, 0, 0);
        add(0, 4'h9, 4'h1, 0, 0, 0);
        add(0, 4'h8, 4'h0, 0, 0, 0);  // drop on expiry edge: no tmo
        add(0, 4'h8, 4'h0, 0, 0, 0);
        add(0, 4'h8, 4'h8, 3, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step_b(tbl[i].rst, tbl[i].req);
            chk("tbl_gnt", i, arb_b.gnt, tbl[i].gnt);
            chk("tbl_busy", i, {3'b0, arb_b.busy}, {3'b0, |tbl[i].gnt});
            chk("tbl_tmo", i, {3'b0, arb_b.tmo}, {3'b0, tbl[i].tmo});
            chk("tbl_nq_idle", i, {3'b0, arb_b.nq_idle}, {3'b0, tbl[i].nq});
            if (tbl[i].gnt != 4'h0) begin
                chk("tbl_owner", i, {2'b0, arb_b.owner}, {2'b0, tbl[i].owner});
            end
        end

        // All four requesting, MAX_HOLD=4: 4 granted, GAP, IDLE, owners rotate.
        step_b(1, 4'hF);
        for (int c = 0; c < 200; c++) begin
            step_b(0, 4'hF);
            ph = c % 6;
            eg = (ph < 4) ? (4'b0001 << ((c / 6) % 4)) : 4'b0000;
            chk("rot_gnt", c, arb_b.gnt, eg);
            chk("rot_tmo", c, {3'b0, arb_b.tmo}, {3'b0, ph == 4});
        end

        // Single requester, MAX_HOLD=16: 16 granted, tmo in GAP, period 18.
        step_a(1, 4'h8);
        for (int c = 0; c < 40; c++) begin
            step_a(0, 4'h8);
            ph = c % 18;
            eg = (ph < 16) ? 4'b1000 : 4'b0000;
            chk("hold_gnt", c, arb_a.gnt, eg);
            chk("hold_tmo", c, {3'b0, arb_a.tmo}, {3'b0, ph == 16});
        end

        // Move ptr to 2, own with i2 until cnt=7, then reset mid-grant.
        step_a(1, 4'h0);
        step_a(0, 4'h2);
        chk("r6_g1", 0, arb_a.gnt, 4'b0010);
        step_a(0, 4'h0);
        step_a(0, 4'h0);
        step_a(0, 4'h4);
        chk("r6_g2", 0, arb_a.gnt, 4'b0100);
        for (int c = 0; c < 7; c++) step_a(0, 4'h4);
        chk("r6_hold", 0, arb_a.gnt, 4'b0100);
        step_a(1, 4'h4);
        chk("r6_rst_gnt", 0, arb_a.gnt, 4'b0000);
        chk("r6_rst_busy", 0, {3'b0, arb_a.busy}, 4'b0000);
        step_a(0, 4'hA);
        chk("r6_regrant", 0, arb_a.gnt, 4'b0010);  // ptr back to 0
        chk("r6_owner", 0, {2'b0, arb_a.owner}, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
